// File: rtl/beta_mem_stage.sv
// Memory stage of a simple in-order pipeline: issues aligned loads/stores on a
// valid/ready data-memory port, extracts load data and produces a registered writeback.
module beta_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              exe_valid_i,
  output logic              exe_ready_o,
  input  logic              exe_mem_op_en_i,
  input  logic              exe_mem_op_i,
  input  logic [1:0]        exe_mem_op_size_i,
  input  logic              exe_mem_unsigned_i,
  input  logic [31:0]       exe_res_i,
  input  logic [31:0]       exe_wdata_i,
  input  logic [4:0]        exe_rd_i,
  input  logic              exe_reg_wr_en_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_rsp_valid_i,
  output logic              dmem_rsp_ready_o,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_reg_wr_en_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, WRDY = 2'b01, WVLD = 2'b10} state_t;

  state_t             r_state, w_state_next;
  logic [ADDR_W-1:0]  w_addr;
  logic [1:0]         w_off;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic               w_misalign, w_accept, w_start;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_we, r_unsigned, r_wr_en;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [4:0]         r_rd;
  logic [1:0]         r_size, r_off;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic               r_wb_valid, r_wb_wr_en, r_misalign;
  logic [4:0]         r_wb_rd;
  logic [31:0]        r_wb_data;

  assign w_addr   = ADDR_W'(exe_res_i);
  assign w_off    = exe_res_i[1:0];
  assign w_accept = exe_valid_i && exe_ready_o;
  assign w_start  = w_accept && exe_mem_op_en_i && !w_misalign;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = WRDY;
      WRDY:    if (dmem_req_ready_i) w_state_next = r_we ? IDLE : WVLD;
      WVLD:    if (dmem_rsp_valid_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    exe_ready_o      = (r_state == IDLE);
    dmem_req_valid_o = (r_state == WRDY);
    dmem_rsp_ready_o = (r_state == WVLD);
  end

  // Lane pattern and replicated store data, plus the alignment check
  always_comb begin
    w_be       = 4'b0000;
    w_wdata    = exe_wdata_i;
    w_misalign = 1'b0;
    case (exe_mem_op_size_i)
      2'b00: begin
        w_be       = 4'b1111;
        w_misalign = (w_off != 2'b00);
      end
      2'b01: begin
        w_be       = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{exe_wdata_i[15:0]}};
        w_misalign = w_off[0];
      end
      2'b10: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{exe_wdata_i[7:0]}};
      end
      default: w_misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_wr_en    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_off      <= '0;
    end else if (w_start) begin
      r_addr     <= {w_addr[ADDR_W-1:2], 2'b00};
      r_we       <= exe_mem_op_i;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_rd       <= exe_rd_i;
      r_wr_en    <= exe_reg_wr_en_i;
      r_unsigned <= exe_mem_unsigned_i;
      r_size     <= exe_mem_op_size_i;
      r_off      <= w_off;
    end
  end

  assign dmem_addr_o  = r_addr;
  assign dmem_we_o    = r_we;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

  assign w_byte = dmem_rdata_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    case (r_size)
      2'b00:   w_load = dmem_rdata_i;
      2'b01:   w_load = {{16{!r_unsigned && w_half[15]}}, w_half};
      default: w_load = {{24{!r_unsigned && w_byte[7]}}, w_byte};
    endcase
  end

  // Writeback pulses come from exactly one of: accept in IDLE, store done, load response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wb_valid <= 1'b0;
      r_wb_wr_en <= 1'b0;
      r_misalign <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      if (w_accept && !exe_mem_op_en_i) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= exe_rd_i;
        r_wb_wr_en <= exe_reg_wr_en_i;
        r_wb_data  <= exe_res_i;
      end else if (w_accept && w_misalign) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= exe_rd_i;
        r_wb_wr_en <= 1'b0;
        r_misalign <= 1'b1;
      end else if (r_state == WRDY && dmem_req_ready_i && r_we) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_wr_en <= 1'b0;
      end else if (r_state == WVLD && dmem_rsp_valid_i) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_wr_en <= r_wr_en;
        r_wb_data  <= w_load;
      end
    end
  end

  assign wb_valid_o     = r_wb_valid;
  assign wb_rd_o        = r_wb_rd;
  assign wb_reg_wr_en_o = r_wb_wr_en;
  assign wb_data_o      = r_wb_data;
  assign misalign_o     = r_misalign;

endmodule

// File: doc/beta_mem_stage.md
BETA_MEM_STAGE -- requirements
Module: beta_mem_stage

Interface
REQ-001 Parameter ADDR_W, default 32, data memory byte-address width; data width SHALL be fixed at 32.
REQ-002 clk_i  in  1  single clock, all state on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 exe_valid_i  in  1  execute stage presents an instruction.
REQ-005 exe_ready_o  out  1  stage can accept; SHALL equal (state == IDLE).
REQ-006 exe_mem_op_en_i / exe_mem_op_i / exe_mem_op_size_i  in  1/1/2  memory op requested / 0 = load, 1 = store / 00 = word, 01 = half, 10 = byte, 11 = reserved.
REQ-007 exe_mem_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 exe_res_i  in  32  ALU result, used as byte address (low ADDR_W bits) for memory ops and as writeback data otherwise.
REQ-009 exe_wdata_i  in  32  store data (rs2).
REQ-010 exe_rd_i / exe_reg_wr_en_i  in  5/1  destination register / register-write request.
REQ-011 dmem_req_valid_o, dmem_req_ready_i  out/in  1/1  request handshake.
REQ-012 dmem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-013 dmem_we_o / dmem_be_o / dmem_wdata_o  out  1/4/32  write enable / byte enables / lane-replicated store data.
REQ-014 dmem_rsp_valid_i, dmem_rsp_ready_o, dmem_rdata_i  in/out/in  1/1/32  load response handshake and data.
REQ-015 wb_valid_o / wb_rd_o / wb_reg_wr_en_o / wb_data_o  out  1/5/1/32  registered writeback to the register file.
REQ-016 misalign_o  out  1  one-cycle pulse, aligned with wb_valid_o, flagging a misaligned or reserved-size access.

Function
REQ-017 The FSM SHALL have three states, encoded in 2 bits: IDLE = 00, WRDY = 01 (wait for request ready), WVLD = 10 (wait for response valid).
REQ-018 An instruction SHALL be accepted on any cycle with exe_valid_i && exe_ready_o; all fields SHALL be latched on that edge.
REQ-019 Non-memory op: state stays IDLE and the next cycle drives wb_valid_o = 1, wb_data_o = exe_res_i, with rd and wr_en passed through (throughput 1 per cycle).
REQ-020 Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0, or size 11) SHALL issue no dmem request; the next cycle drives wb_valid_o = 1, wb_reg_wr_en_o = 0, misalign_o = 1, and state stays IDLE.
REQ-021 Aligned memory op: IDLE -> WRDY; while in WRDY, dmem_req_valid_o = 1 and addr/we/be/wdata SHALL be held stable until dmem_req_ready_i.
REQ-022 Byte enables: word = 1111; half = 0011 when addr[1] = 0, else 1100; byte = 0001 << addr[1:0]; for loads, dmem_be_o SHALL carry the same pattern.
REQ-023 Store data: word passed as-is; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
REQ-024 Store: when WRDY and dmem_req_ready_i -> IDLE; the next cycle drives wb_valid_o = 1 with wb_reg_wr_en_o = 0 (no response expected).
REQ-025 Load: when WRDY and dmem_req_ready_i -> WVLD; in WVLD, dmem_rsp_ready_o = 1 and dmem_req_valid_o = 0.
REQ-026 Load: when WVLD and dmem_rsp_valid_i -> IDLE, and the next cycle drives wb_valid_o = 1 with the extracted data (byte lane addr[1:0], half lane addr[1]), sign- or zero-extended per REQ-007, and with rd and wr_en from the latched instruction.
REQ-027 dmem_rsp_ready_o SHALL be 0 outside WVLD; dmem_rsp_valid_i outside WVLD SHALL be ignored and dropped.
REQ-028 wb_valid_o and misalign_o SHALL be single-cycle pulses; wb_* fields are don't-care when wb_valid_o = 0.
REQ-029 Minimum latency, acceptance to wb_valid_o: non-memory op 1 cycle; store 2 cycles; load 3 cycles (with ready and valid returned immediately).

Reset
REQ-030 While rst_n_i = 0: state = IDLE and wb_valid_o, misalign_o, dmem_req_valid_o, dmem_rsp_ready_o, dmem_we_o = 0; dmem_be_o = 0000; all data/address outputs = 0.
REQ-031 Reset asserted mid-transaction (WRDY or WVLD) SHALL abort it with no writeback; a late response after reset is dropped per REQ-027.

Verification
REQ-032 Three back-to-back non-memory ops with exe_res_i = 0x11, 0x22, 0x33 -> wb_valid_o high three consecutive cycles carrying 0x11, 0x22, 0x33; exe_ready_o held 1.
REQ-033 Byte store, addr 0x103, wdata 0xAABBCCDD, ready stalled 2 cycles -> dmem_addr_o = 0x100, be = 1000, wdata = 0xDDDDDDDD held 3 cycles, then wb_valid_o with wr_en = 0.
REQ-034 Signed half load, addr 0x202, rdata 0x8001FFFF -> wb_data_o = 0xFFFF8001; same access with unsigned = 1 -> 0x00008001.
REQ-035 Word load, addr 0x301 -> no dmem_req_valid_o; next cycle misalign_o = 1, wb_valid_o = 1, wb_reg_wr_en_o = 0.
REQ-036 Load in WVLD, reset pulsed, then dmem_rsp_valid_i = 1 -> no wb_valid_o; state IDLE; exe_ready_o = 1.
REQ-037 dmem_rsp_valid_i asserted while IDLE, then load with rsp delayed 4 cycles -> stray response ignored; wb_valid_o fires once, the cycle after the real response.
